pwm_fade_sched: RTL
===================

// Module: pwm_fade_sched
// PURPOSE
//  Fade scheduler between the SPI command decode and the pwm channel array.
//  Holds a target and a current threshold per channel; on every fade_div-th
//  counter overflow it steps each current value toward its target. Changed
//  values go to the pwm channels over the shared new_thres/set_thres write
//  bus, one channel per cycle. SPI commands set targets, optionally with an
//  immediate jump.
// PARAMETERS
//  pwm_width  8   threshold width; matches the counter and pwm width
//  num_pwm    12  number of pwm channels
//  step       1   per-fade-tick increment/decrement magnitude, >= 1
//  fade_div   4   overflows per fade tick, >= 1
// PORTS
//  clk          in   1              system clock
//  reset        in   1              asynchronous, active-high
//  overflow     in   1              1-cycle pulse from the counter wrap
//  cmd_valid    in   1              command strobe from SPI decode
//  cmd_chan     in   pwm_bits       target channel, pwm_bits=$clog2(num_pwm)
//  cmd_target   in   pwm_width      new target threshold
//  cmd_imm      in   1              1: current := target immediately
//  new_thres    out  pwm_width      write data to the pwm array
//  set_thres    out  num_pwm        one-hot write strobe, at most 1 bit set
//  busy         out  1              scan running or any dirty bit set
//  cmd_error    out  1              1-cycle pulse: cmd_chan >= num_pwm
// BEHAVIOUR
//  Reset: cur[]=0, tgt[]=0, dirty[]=0; new_thres=0, set_thres=0, busy=0,
//   cmd_error=0; FSM IDLE; div_cnt=0; ovf_pend=0. Reset mid-scan or mid-write
//   aborts the operation with no further set_thres pulse.
//  Commands: accepted every cycle, never back-pressured. A valid channel
//   loads tgt. If cmd_imm=1, it also loads cur and sets dirty. Out-of-range
//   channels change no state, and cmd_error is high the next cycle.
//  Divider: each overflow increments div_cnt. At fade_div-1 the counter wraps
//   to 0 and raises ovf_pend (sticky). An overflow while ovf_pend=1 is dropped.
//  FSM IDLE: if ovf_pend, clear it, idx=0, go SCAN.
//  FSM SCAN: one channel per cycle at idx. If cur!=tgt, cur moves toward tgt
//   by min(step,|tgt-cur|) and dirty[idx] is set; cur never overshoots or
//   wraps. Math is done in pwm_width+1 bits. When idx=num_pwm-1, go to IDLE.
//  Same cycle, same channel, command vs scan: command wins. tgt takes the
//   command value. cur takes cmd_target if cmd_imm, else the scan step is
//   computed from the pre-command tgt.
//  Writer, independent of the FSM: each cycle it picks the lowest-index dirty
//   channel k. Next cycle: new_thres=cur[k] as sampled, set_thres=1<<k, and
//   dirty[k] is cleared. Otherwise set_thres=0 and new_thres holds its value.
//   If dirty[k] is set again in the cycle it is cleared, set wins and k is
//   rewritten later with the newer cur.
//  Latency: cmd_imm write -> set_thres pulse 2 cycles later if no other
//   channel is dirty. Throughput: 1 write/cycle, so a full scan drains in
//   <= num_pwm cycles after its last step.
//  busy = (state==SCAN) | ovf_pend | (|dirty), registered.
// STRUCTURE
//  Package pulsar_pkg: pwm_width, num_pwm, pwm_bits localparams; the
//   state_t enum {IDLE, SCAN}; and a thres_t typedef. The SPI word split is
//   shared there with the top level.
//  Sub-module pwm_step: combinational (cur,tgt,step) -> next cur, clamped;
//   unit-testable on its own.
//  Writer priority pick is an inline lowest-set-bit loop.
// TESTING
//  1 reset, cmd ch3 tgt=0x40 imm=1 -> 2 cycles later set_thres=0x008,
//    new_thres=0x40, single pulse; busy drops the next cycle.
//  2 fade_div=4, step=1, cmd ch0 tgt=3 imm=0 -> writes of 1,2,3 on ch0 after
//    overflows #4, #8, #12; none after #16.
//  3 step=16, cur=0xF8, tgt=0xFF -> one write of 0xFF, no wrap to 0x08;
//    tgt=0x02 from 0x0A -> 0x02 directly.
//  4 cmd_chan=12 with num_pwm=12 -> cmd_error pulses 1 cycle, no set_thres,
//    state unchanged.
//  5 cmd ch5 imm=1 in the same cycle the scan visits ch5 -> cur=cmd_target,
//    exactly one write carrying cmd_target; set_thres is never multi-hot.
//  6 overflow pulses 2 cycles apart during a scan (fade_div=1) -> second pulse
//    dropped or pended per rule; reset asserted mid-scan -> outputs 0 at once.

Source files
------------

// File: rtl/pulsar_pkg.sv
// Shared types and sizes for the fade scheduler and its SPI command decode.
package pulsar_pkg;
    localparam int pwm_width = 8;
    localparam int num_pwm   = 12;
    localparam int pwm_bits  = $clog2(num_pwm);

    typedef logic [pwm_width-1:0] thres_t;
    typedef logic [pwm_bits-1:0]  chan_t;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    // SPI command word layout, MSB first: imm | channel | target
    typedef struct packed {
        logic   imm;
        chan_t  chan;
        thres_t target;
    } spi_cmd_t;

    function automatic logic chan_in_range(input chan_t chan);
        return ({1'b0, chan} < (pwm_bits+1)'(num_pwm));
    endfunction
endpackage

// File: rtl/pwm_fade_sched_if.sv
// Command input and threshold write bus between SPI decode, scheduler and pwm array.
interface pwm_fade_sched_if;
    import pulsar_pkg::*;

    logic                 cmd_valid;
    chan_t                cmd_chan;
    thres_t               cmd_target;
    logic                 cmd_imm;
    thres_t               new_thres;
    logic [num_pwm-1:0]   set_thres;
    logic                 busy;
    logic                 cmd_error;

    modport master (
        output cmd_valid, cmd_chan, cmd_target, cmd_imm,
        input  new_thres, set_thres, busy, cmd_error
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_target, cmd_imm,
        output new_thres, set_thres, busy, cmd_error
    );
endinterface

// File: rtl/pwm_step.sv
// One fade step: move cur toward tgt by at most step, never past tgt.
module pwm_step
    import pulsar_pkg::*;
#(
    parameter int width = pwm_width,
    parameter int step  = 1
) (
    input  logic [width-1:0] cur_i,
    input  logic [width-1:0] tgt_i,
    output logic [width-1:0] nxt_o
);
    logic [width:0] cur_w;
    logic [width:0] tgt_w;
    logic [width:0] stp_w;
    logic [width:0] dist_w;
    logic [width:0] res_w;

    // Extra headroom bit keeps the add from wrapping near full scale
    always_comb begin
        cur_w = {1'b0, cur_i};
        tgt_w = {1'b0, tgt_i};
        stp_w = (width+1)'(step);
        if (tgt_w > cur_w) begin
            dist_w = tgt_w - cur_w;
            res_w  = cur_w + ((dist_w < stp_w) ? dist_w : stp_w);
        end else begin
            dist_w = cur_w - tgt_w;
            res_w  = cur_w - ((dist_w < stp_w) ? dist_w : stp_w);
        end
    end

    assign nxt_o = width'(res_w);
endmodule

// File: rtl/pwm_fade_sched.sv
// Fade scheduler: steps per-channel thresholds toward SPI targets on divided
// counter overflows and streams changed values to the pwm array.
module pwm_fade_sched
    import pulsar_pkg::*;
#(
    parameter int step     = 1,
    parameter int fade_div = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              overflow,
    pwm_fade_sched_if.slave   bus
);
    localparam int div_bits = (fade_div > 1) ? $clog2(fade_div) : 1;

    state_t               state_q, state_d;
    chan_t                idx_q, idx_d;
    logic [div_bits-1:0]  div_cnt_q, div_cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    thres_t               cur_q [num_pwm];
    thres_t               cur_d [num_pwm];
    thres_t               tgt_q [num_pwm];
    thres_t               tgt_d [num_pwm];
    logic [num_pwm-1:0]   dirty_q, dirty_d;
    thres_t               new_thres_q, new_thres_d;
    logic [num_pwm-1:0]   set_thres_q, set_thres_d;
    logic                 busy_q, busy_d;
    logic                 cmd_error_q, cmd_error_d;

    spi_cmd_t             cmd_s;
    thres_t               step_cur_s;
    logic                 pick_found_s;
    chan_t                pick_s;

    assign cmd_s = {bus.cmd_imm, bus.cmd_chan, bus.cmd_target};

    pwm_step #(.width(pwm_width), .step(step)) u_step (
        .cur_i (cur_q[idx_q]),
        .tgt_i (tgt_q[idx_q]),
        .nxt_o (step_cur_s)
    );

    // Lowest-index dirty channel gets the write bus
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = '0;
        for (int i = num_pwm - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                pick_found_s = 1'b1;
                pick_s       = chan_t'(i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        div_cnt_d   = div_cnt_q;
        ovf_pend_d  = ovf_pend_q;
        cur_d       = cur_q;
        tgt_d       = tgt_q;
        dirty_d     = dirty_q;
        new_thres_d = new_thres_q;
        set_thres_d = '0;
        cmd_error_d = 1'b0;
        busy_d      = (state_q == SCAN) | ovf_pend_q | (|dirty_q);

        if (pick_found_s) begin
            new_thres_d         = cur_q[pick_s];
            set_thres_d[pick_s] = 1'b1;
            dirty_d[pick_s]     = 1'b0;
        end else begin
            new_thres_d = new_thres_q;
        end

        case (state_q)
            IDLE: begin
                if (ovf_pend_q) begin
                    ovf_pend_d = 1'b0;
                    idx_d      = '0;
                    state_d    = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (step_cur_s != cur_q[idx_q]) begin
                    cur_d[idx_q]   = step_cur_s;
                    dirty_d[idx_q] = 1'b1;
                end else begin
                    cur_d[idx_q] = cur_q[idx_q];
                end
                if (idx_q == chan_t'(num_pwm - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + chan_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A pulse arriving while a tick is already pending is dropped uncounted
        if (overflow && !ovf_pend_q) begin
            if (div_cnt_q == div_bits'(fade_div - 1)) begin
                div_cnt_d  = '0;
                ovf_pend_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + div_bits'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end

        // Command is applied last so it overrides the scan on the same channel
        if (bus.cmd_valid) begin
            if (chan_in_range(cmd_s.chan)) begin
                tgt_d[cmd_s.chan] = cmd_s.target;
                if (cmd_s.imm) begin
                    cur_d[cmd_s.chan]   = cmd_s.target;
                    dirty_d[cmd_s.chan] = 1'b1;
                end else begin
                    dirty_d[cmd_s.chan] = dirty_d[cmd_s.chan];
                end
            end else begin
                cmd_error_d = 1'b1;
            end
        end else begin
            cmd_error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            div_cnt_q   <= '0;
            ovf_pend_q  <= 1'b0;
            cur_q       <= '{default: '0};
            tgt_q       <= '{default: '0};
            dirty_q     <= '0;
            new_thres_q <= '0;
            set_thres_q <= '0;
            busy_q      <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            div_cnt_q   <= div_cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            dirty_q     <= dirty_d;
            new_thres_q <= new_thres_d;
            set_thres_q <= set_thres_d;
            busy_q      <= busy_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    assign bus.new_thres = new_thres_q;
    assign bus.set_thres = set_thres_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_error = cmd_error_q;
endmodule
